truth_table_probe: RTL and testbench

- Sequential characterizer for 3-input, 1-output combinational gate circuits.
- Drives all 8 input combinations onto the circuit's {in1,in2,in3} inputs and waits a settle time for each.
- Samples the circuit's `out` for each combination and assembles the 8-bit truth-table code in the team's hex naming (a circuit named 0x5C reads back 8'h5C).
- Compares the assembled code against an expected code.
- Used as the on-chip/bench reader for the generated combinational gate modules.

---
 rtl/truth_table_probe.sv | 131 +++++++++++++
 tb/tb_truth_table_probe.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_probe.sv
// Sequential truth-table reader for 3-input, 1-output gate circuits.
// Walks stim through 000..111, samples dut_out twice per row, and reports the 8-bit code.
module truth_table_probe #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic [2:0] stim,
    output logic       busy,
    output logic       done,
    output logic [7:0] code,
    output logic       match,
    output logic       stable
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(SETTLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       state, state_nxt;
    logic [2:0]       row, row_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pre, pre_nxt;
    logic [7:0]       exp_q, exp_nxt;
    logic [2:0]       stim_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic [7:0]       code_nxt;
    logic             match_nxt;
    logic             stable_nxt;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            row    <= 3'd0;
            cnt    <= '0;
            pre    <= 1'b0;
            exp_q  <= 8'h00;
            stim   <= 3'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            code   <= 8'h00;
            match  <= 1'b0;
            stable <= 1'b0;
        end else begin
            state  <= state_nxt;
            row    <= row_nxt;
            cnt    <= cnt_nxt;
            pre    <= pre_nxt;
            exp_q  <= exp_nxt;
            stim   <= stim_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            code   <= code_nxt;
            match  <= match_nxt;
            stable <= stable_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt  = state;
        row_nxt    = row;
        cnt_nxt    = cnt;
        pre_nxt    = pre;
        exp_nxt    = exp_q;
        stim_nxt   = stim;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        code_nxt   = code;
        match_nxt  = match;
        stable_nxt = stable;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = RUN;
                    exp_nxt    = expected;
                    row_nxt    = 3'd0;
                    stim_nxt   = 3'd0;
                    cnt_nxt    = '0;
                    code_nxt   = 8'h00;
                    stable_nxt = 1'b1;
                    busy_nxt   = 1'b1;
                end
            end

            RUN: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == PRE_CNT) begin
                    pre_nxt = dut_out;
                end
                if (cnt == LAST_CNT) begin
                    // Row k lands in code[7-k]; ~row is 7-row for a 3-bit row.
                    code_nxt[~row] = dut_out;
                    if (dut_out != pre) begin
                        stable_nxt = 1'b0;
                    end
                    cnt_nxt = '0;
                    if (row == 3'd7) begin
                        state_nxt = FINISH;
                        stim_nxt  = 3'd0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        match_nxt = (code_nxt == exp_q);
                    end else begin
                        row_nxt  = row + 3'd1;
                        stim_nxt = row + 3'd1;
                    end
                end
            end

            FINISH: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_truth_table_probe.sv
// Self-checking bench for truth_table_probe: gate circuits modelled from their hex name,
// runs at SETTLE_CYCLES=4 and =2 checked against expected code/match/stable/timing.
module tb_truth_table_probe;

    logic       clk;
    logic       rst_n;

    logic       start_a, dut_out_a, busy_a, done_a, match_a, stable_a;
    logic [7:0] expected_a, code_a, gate_a;
    logic [2:0] stim_a;
    logic       glitch_a;

    logic       start_b, dut_out_b, busy_b, done_b, match_b, stable_b;
    logic [7:0] expected_b, code_b, gate_b;
    logic [2:0] stim_b;

    int checks;
    int errors;

    // results of the last run_a
    int         r_done_cyc;
    int         r_ndone;
    logic       r_busy_at_done;
    logic       r_seq_ok;
    int         r_seq_bad_cyc;
    logic [2:0] r_rst_stim;
    logic       r_rst_busy;
    logic [7:0] r_rst_code;
    logic [7:0] r_code;
    logic       r_match;
    logic       r_stable;
    logic       r_busy_end;

    truth_table_probe #(.SETTLE_CYCLES(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .expected(expected_a),
        .dut_out(dut_out_a), .stim(stim_a), .busy(busy_a), .done(done_a),
        .code(code_a), .match(match_a), .stable(stable_a)
    );

    truth_table_probe #(.SETTLE_CYCLES(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .expected(expected_b),
        .dut_out(dut_out_b), .stim(stim_b), .busy(busy_b), .done(done_b),
        .code(code_b), .match(match_b), .stable(stable_b)
    );

    // A gate named 0xNN outputs bit (7-k) of NN for input row k.
    assign dut_out_a = gate_a[3'd7 - stim_a] ^ glitch_a;
    assign dut_out_b = gate_b[3'd7 - stim_b];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One run on the SETTLE_CYCLES=4 probe; cycle n is the n-th cycle after the start edge.
    task automatic run_a(input logic [7:0] g, input logic [7:0] ex, input int glitch_cyc,
                         input int rs1, input int rs2, input int rst_cyc);
        int         exp_stim;
        logic       exp_busy;
        r_done_cyc     = -1;
        r_ndone        = 0;
        r_busy_at_done = 1'b1;
        r_seq_ok       = 1'b1;
        r_seq_bad_cyc  = 0;
        @(negedge clk);
        gate_a     = g;
        expected_a = ex;
        glitch_a   = 1'b0;
        start_a    = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (rst_cyc != 0 && n == rst_cyc + 1) rst_n = 1'b1;
            if (done_a === 1'b1) begin
                r_ndone++;
                if (r_done_cyc < 0) begin
                    r_done_cyc     = n;
                    r_busy_at_done = busy_a;
                end
            end
            exp_stim = (n <= 32) ? (n - 1) / 4 : 0;
            exp_busy = (n <= 32);
            if ((rst_cyc == 0 || n < rst_cyc) &&
                (stim_a !== 3'(exp_stim) || busy_a !== exp_busy) && r_seq_ok) begin
                r_seq_ok      = 1'b0;
                r_seq_bad_cyc = n;
            end
            start_a  = (n == rs1 || n == rs2);
            glitch_a = (n == glitch_cyc);
            if (n == 10) expected_a = ~ex;
            if (n == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                r_rst_stim = stim_a;
                r_rst_busy = busy_a;
                r_rst_code = code_a;
            end
        end
        start_a    = 1'b0;
        glitch_a   = 1'b0;
        r_code     = code_a;
        r_match    = match_a;
        r_stable   = stable_a;
        r_busy_end = busy_a;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({stim_a, busy_a, done_a, code_a, match_a, stable_a} !== 14'd0) begin
            errors++;
            $display("FAIL reset_a: got stim=%0d busy=%b done=%b code=%h match=%b stable=%b, want all zero",
                     stim_a, busy_a, done_a, code_a, match_a, stable_a);
        end
        checks++;
        if ({stim_b, busy_b, done_b, code_b, match_b, stable_b} !== 14'd0) begin
            errors++;
            $display("FAIL reset_b: got stim=%0d busy=%b done=%b code=%h match=%b stable=%b, want all zero",
                     stim_b, busy_b, done_b, code_b, match_b, stable_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got busy=%b done=%b, want 0 0", busy_a, done_a);
        end
    endtask

    task automatic test_match;
        run_a(8'h5C, 8'h5C, 0, 0, 0, 0);
        checks++;
        if (r_code !== 8'h5C || r_match !== 1'b1 || r_stable !== 1'b1) begin
            errors++;
            $display("FAIL match_5c: got code=%h match=%b stable=%b, want 5c 1 1", r_code, r_match, r_stable);
        end
        checks++;
        if (r_done_cyc != 33 || r_ndone != 1) begin
            errors++;
            $display("FAIL done_latency: got cycle=%0d pulses=%0d, want 33 1", r_done_cyc, r_ndone);
        end
        checks++;
        if (r_busy_at_done !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done: got %b, want 0", r_busy_at_done);
        end
    endtask

    task automatic test_mismatch_and_stim;
        run_a(8'h5C, 8'h5D, 0, 0, 0, 0);
        checks++;
        if (r_code !== 8'h5C || r_match !== 1'b0 || r_stable !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_5d: got code=%h match=%b stable=%b, want 5c 0 1", r_code, r_match, r_stable);
        end
        checks++;
        if (r_seq_ok !== 1'b1) begin
            errors++;
            $display("FAIL stim_sequence: first bad cycle=%0d, want none", r_seq_bad_cyc);
        end
    endtask

    task automatic test_glitch;
        // Cycle 15 ends on the row-3 pre-sample edge.
        run_a(8'h5C, 8'h5C, 15, 0, 0, 0);
        checks++;
        if (r_code !== 8'h5C || r_match !== 1'b1 || r_stable !== 1'b0) begin
            errors++;
            $display("FAIL glitch_row3: got code=%h match=%b stable=%b, want 5c 1 0", r_code, r_match, r_stable);
        end
        run_a(8'h5C, 8'h5C, 0, 0, 0, 0);
        checks++;
        if (r_stable !== 1'b1) begin
            errors++;
            $display("FAIL stable_restore: got %b, want 1", r_stable);
        end
    endtask

    task automatic test_restart_ignored;
        run_a(8'hFF, 8'hFF, 0, 5, 20, 0);
        checks++;
        if (r_ndone != 1 || r_done_cyc != 33 || r_seq_ok !== 1'b1) begin
            errors++;
            $display("FAIL restart_ignored: got pulses=%0d cycle=%0d seq_ok=%b, want 1 33 1",
                     r_ndone, r_done_cyc, r_seq_ok);
        end
        checks++;
        if (r_code !== 8'hFF || r_match !== 1'b1) begin
            errors++;
            $display("FAIL const_one: got code=%h match=%b, want ff 1", r_code, r_match);
        end
    endtask

    task automatic test_back_to_back;
        // start during the done cycle is not honoured
        run_a(8'h96, 8'h96, 0, 33, 0, 0);
        checks++;
        if (r_ndone != 1 || r_busy_end !== 1'b0 || r_code !== 8'h96) begin
            errors++;
            $display("FAIL start_on_done: got pulses=%0d busy=%b code=%h, want 1 0 96",
                     r_ndone, r_busy_end, r_code);
        end
    endtask

    task automatic test_midrun_reset;
        run_a(8'h5C, 8'h5C, 0, 0, 0, 15);
        checks++;
        if (r_rst_stim !== 3'd0 || r_rst_busy !== 1'b0 || r_rst_code !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got stim=%0d busy=%b code=%h, want 0 0 00",
                     r_rst_stim, r_rst_busy, r_rst_code);
        end
        checks++;
        if (r_ndone != 0 || r_code !== 8'h00) begin
            errors++;
            $display("FAIL reset_no_done: got pulses=%0d code=%h, want 0 00", r_ndone, r_code);
        end
        run_a(8'h5C, 8'h5C, 0, 0, 0, 0);
        checks++;
        if (r_code !== 8'h5C || r_match !== 1'b1 || r_done_cyc != 33) begin
            errors++;
            $display("FAIL after_reset: got code=%h match=%b cycle=%0d, want 5c 1 33",
                     r_code, r_match, r_done_cyc);
        end
    endtask

    task automatic test_random;
        logic [7:0] g;
        logic [7:0] ex;
        logic       exp_match;
        for (int i = 0; i < 8; i++) begin
            g  = 8'($urandom);
            ex = ($urandom_range(1, 0) == 1) ? g : 8'($urandom);
            exp_match = (ex == g);
            run_a(g, ex, 0, 0, 0, 0);
            checks++;
            if (r_code !== g || r_match !== exp_match || r_stable !== 1'b1 || r_done_cyc != 33) begin
                errors++;
                $display("FAIL random_%0d: got code=%h match=%b stable=%b cycle=%0d, want %h %b 1 33",
                         i, r_code, r_match, r_stable, r_done_cyc, g, exp_match);
            end
        end
    endtask

    // SETTLE_CYCLES=2 probe: done expected 8*2+1 cycles after start
    task automatic test_settle2;
        logic [7:0] gates [2];
        int         done_cyc;
        int         ndone;
        gates[0] = 8'h80;
        gates[1] = 8'($urandom);
        for (int t = 0; t < 2; t++) begin
            done_cyc = -1;
            ndone    = 0;
            @(negedge clk);
            gate_b     = gates[t];
            expected_b = gates[t];
            start_b    = 1'b1;
            @(posedge clk);
            for (int n = 1; n <= 25; n++) begin
                @(negedge clk);
                start_b = 1'b0;
                if (done_b === 1'b1) begin
                    ndone++;
                    if (done_cyc < 0) done_cyc = n;
                end
            end
            checks++;
            if (code_b !== gates[t] || match_b !== 1'b1 || stable_b !== 1'b1) begin
                errors++;
                $display("FAIL settle2_code_%0d: got code=%h match=%b stable=%b, want %h 1 1",
                         t, code_b, match_b, stable_b, gates[t]);
            end
            checks++;
            if (done_cyc != 17 || ndone != 1) begin
                errors++;
                $display("FAIL settle2_latency_%0d: got cycle=%0d pulses=%0d, want 17 1", t, done_cyc, ndone);
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        start_a    = 1'b0;
        start_b    = 1'b0;
        expected_a = 8'h00;
        expected_b = 8'h00;
        gate_a     = 8'h00;
        gate_b     = 8'h00;
        glitch_a   = 1'b0;
        test_reset();
        test_match();
        test_mismatch_and_stim();
        test_glitch();
        test_restart_ignored();
        test_back_to_back();
        test_midrun_reset();
        test_random();
        test_settle2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
